// File: rtl/msrh_sched_age_picker_if.sv
// Issue-select bundle between the scheduler entry array and the age picker.
// The entry array drives master; the picker is the slave.
interface msrh_sched_age_picker_if #(
    parameter int ENTRY_SIZE = 8,
    parameter int DATA_W     = 64,
    parameter int IDX_W      = $clog2(ENTRY_SIZE)
);
    logic [ENTRY_SIZE-1:0]        i_put_oh;
    logic [ENTRY_SIZE-1:0]        i_entry_valid;
    logic [ENTRY_SIZE-1:0]        i_entry_ready;
    logic [ENTRY_SIZE*DATA_W-1:0] i_entry_data;
    logic                         i_stall;
    logic                         i_flush;
    logic [ENTRY_SIZE-1:0]        o_entry_picked;
    logic                         o_issue_valid;
    logic [IDX_W-1:0]             o_issue_index;
    logic [DATA_W-1:0]            o_issue_data;

    modport master (
        output i_put_oh, i_entry_valid, i_entry_ready, i_entry_data,
        output i_stall, i_flush,
        input  o_entry_picked, o_issue_valid, o_issue_index, o_issue_data
    );

    modport slave (
        input  i_put_oh, i_entry_valid, i_entry_ready, i_entry_data,
        input  i_stall, i_flush,
        output o_entry_picked, o_issue_valid, o_issue_index, o_issue_data
    );
endinterface

// File: rtl/msrh_sched_age_picker.sv
// Oldest-ready issue select: age matrix over scheduler entries feeding
// the EX0 issue register.
module msrh_sched_age_picker #(
    parameter int ENTRY_SIZE = 8,
    parameter int DATA_W     = 64,
    parameter int IDX_W      = $clog2(ENTRY_SIZE)
) (
    input logic                    i_clk,
    input logic                    i_reset,
    msrh_sched_age_picker_if.slave bus
);

    // age_q[i][j] set means entry i is older than entry j
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] age_q;
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] age_d;
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] older;

    logic [ENTRY_SIZE-1:0] req;
    logic [ENTRY_SIZE-1:0] win;
    logic [ENTRY_SIZE-1:0] winner_oh;
    logic [IDX_W-1:0]      win_idx;
    logic [DATA_W-1:0]     win_data;
    logic                  en;

    logic              issue_valid_q;
    logic              issue_valid_d;
    logic [IDX_W-1:0]  issue_index_q;
    logic [IDX_W-1:0]  issue_index_d;
    logic [DATA_W-1:0] issue_data_q;
    logic [DATA_W-1:0] issue_data_d;

    assign req = bus.i_entry_valid & bus.i_entry_ready;
    assign en  = !bus.i_stall && !bus.i_flush && !i_reset;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (bus.i_put_oh[i]) begin
                for (int j = 0; j < ENTRY_SIZE; j++) begin
                    if (j != i) begin
                        if (bus.i_put_oh[j]) begin
                            age_d[i][j] = (i < j);
                        end else if (bus.i_entry_valid[j]) begin
                            age_d[j][i] = 1'b1;
                            age_d[i][j] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // older[i] collects the entries that are older than entry i
    always_comb begin
        older = '0;
        win   = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            for (int j = 0; j < ENTRY_SIZE; j++) begin
                older[i][j] = age_q[j][i] && (j != i);
            end
            win[i] = req[i] && ((older[i] & req) == '0);
        end
    end

    // Lowest-index isolate keeps the strobe one-hot on a corrupt matrix
    assign winner_oh = win & (~win + 1'b1);

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (winner_oh[i]) begin
                win_idx  = IDX_W'(i);
                win_data = bus.i_entry_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        issue_data_d  = issue_data_q;
        if (bus.i_flush) begin
            issue_valid_d = 1'b0;
        end else if (!bus.i_stall) begin
            issue_valid_d = |req;
            if (|req) begin
                issue_index_d = win_idx;
                issue_data_d  = win_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            age_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            issue_data_q  <= '0;
        end else begin
            age_q         <= age_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            issue_data_q  <= issue_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            a_put_free: assert ((bus.i_put_oh & bus.i_entry_valid) == '0);
            a_one_win:  assert ($onehot0(win));
        end
    end

    assign bus.o_entry_picked = winner_oh & {ENTRY_SIZE{en}};
    assign bus.o_issue_valid  = issue_valid_q;
    assign bus.o_issue_index  = issue_index_q;
    assign bus.o_issue_data   = issue_data_q;

endmodule

// File: doc/msrh_sched_age_picker.md
Name: msrh_sched_age_picker

Overview:
- Issue-select stage directly downstream of the scheduler entry array.
- Keeps an age matrix over all scheduler entries and, each cycle, picks the oldest entry that is valid and ready.
- Returns a one-hot picked strobe to the entries and registers the picked payload into the EX0 issue register.
- Flush and stall from the pipeline gate picking and kill or hold the issue register.

Parameters:
- ENTRY_SIZE, 8, number of scheduler entries (2..32).
- DATA_W, 64, width of one flattened issue payload.
- IDX_W, $clog2(ENTRY_SIZE), entry index width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_put_oh  in  ENTRY_SIZE  entries allocated this cycle; may be multi-hot.
- i_entry_valid  in  ENTRY_SIZE  per-entry valid.
- i_entry_ready  in  ENTRY_SIZE  per-entry operands ready and not issued.
- i_entry_data  in  ENTRY_SIZE*DATA_W  per-entry issue payload; entry k occupies bits [k*DATA_W +: DATA_W].
- i_stall  in  1  EX0 cannot accept a new issue.
- i_flush  in  1  pipeline flush.
- o_entry_picked  out  ENTRY_SIZE  one-hot pick strobe, combinational, same cycle.
- o_issue_valid  out  1  EX0 issue register valid.
- o_issue_index  out  IDX_W  entry index of the issued instruction.
- o_issue_data  out  DATA_W  issued payload.

Behaviour:
- Reset (synchronous, i_reset=1 at a posedge):
  - age matrix cleared to all 0.
  - o_issue_valid=0, o_issue_index=0, o_issue_data=0.
  - Reset mid-pick drops the pick; o_entry_picked is forced to 0 while i_reset=1.
- Age matrix: bit age[i][j]=1 means entry i is older than entry j. Diagonal is don't-care.
- Allocate, for each i with i_put_oh[i]=1, applied on the next edge:
  - age[j][i]=1 for every j with i_entry_valid[j]=1 and i_put_oh[j]=0.
  - age[i][j]=0 for those same j.
  - For two puts i<k in the same cycle: age[i][k]=1 and age[k][i]=0, so the lower index is older.
  - Rows and columns of non-put entries are unchanged.
  - A put to an entry with i_entry_valid=1 is illegal; flag it with an assertion.
- Request vector: req[i] = i_entry_valid[i] & i_entry_ready[i].
- Pick rule: entry i wins iff req[i]=1 and no j with req[j]=1 and age[j][i]=1. Exactly one winner exists whenever req is nonzero.
  - Defensive fallback: if the matrix state ever yields multiple winners, pick the lowest index. Assert it never happens.
- Pick enable: en = !i_stall & !i_flush & !i_reset.
  - o_entry_picked = winner_oh & {ENTRY_SIZE{en}}.
- Issue register, on each posedge (priority order):
  1. i_reset: clear.
  2. i_flush: o_issue_valid<=0; index and data don't-care.
  3. i_stall: hold all three outputs unchanged.
  4. Otherwise: o_issue_valid<=|req; on a pick, o_issue_index<=winner index and o_issue_data<=payload of the winner.
- Latency: pick in cycle N, o_issue_valid in cycle N+1.
- The picked entry deasserts ready itself by N+1. The picker does not mask it.
- Entries freed (valid dropped) need no matrix update. The stale row and column are ignored because req is 0, and they are rewritten on the next put.
- A put and a pick in the same cycle: a freshly put entry cannot be picked that cycle (its valid is not yet set). From the next cycle it is youngest.
- A stall held for many cycles:
  - no o_entry_picked pulses;
  - the issue register holds and the age matrix still updates on puts;
  - on release, the current oldest ready entry is picked.
- Flush and stall together: flush wins; the register is cleared.
- Full matrix at ENTRY_SIZE valid entries is legal. No counter or wrap behaviour exists; age is purely relative.

Test Plan:
- Reset: hold i_reset=1 for 2 cycles with req=8'hFF → o_entry_picked=0 throughout; after release o_issue_valid=0 and the matrix is all zero.
- Order: put entries 5, 2, 7 on cycles 1, 2, 3; assert ready on all three on cycle 5 → picks 5 at cycle 5, 2 at cycle 6, 7 at cycle 7 (each pick's ready dropped next cycle); o_issue_index = 5, 2, 7 on cycles 6–8.
- Same-cycle put: i_put_oh=8'b0100_1010 (entries 1, 3, 6) in one cycle, all ready → pick order 1, 3, 6.
- Stall: two ready entries with i_stall=1 for 4 cycles → o_entry_picked=0 and o_issue_* held at the prior value; stall drops → oldest picked, o_issue_valid=1 the following cycle.
- Flush: pick entry 4 at cycle N with i_flush=1 at cycle N+1 → o_issue_valid=0 at N+2 and o_entry_picked=0 during N+1.
- Reuse: entry 0 is oldest, issues, and its valid is dropped; it is later re-put while entries 3 and 6 are still valid → entry 0 is picked after 3 and 6.
